// File: rtl/lvdt_demod_avg.sv
// LVDT synchronous demodulator: samples a thermometer-coded ADC once per excitation
// half-period and reports the average of 2^AVG_LOG2 positive-minus-negative differences.
module lvdt_demod_avg #(
  parameter int SAMPLE_DLY = 10,
  parameter int AVG_LOG2   = 3,
  parameter int TIMEOUT    = 64
) (
  input  logic              mclk,
  input  logic              mrst,
  input  logic              inp,
  input  logic [4:0]        adcbits,
  output logic signed [3:0] pos_data,
  output logic              pos_valid,
  input  logic              pos_ready,
  output logic              code_err,
  output logic              overrun,
  output logic              exc_lost
);
  localparam int ACC_W = 4 + AVG_LOG2;
  localparam int CNT_W = AVG_LOG2 + 1;
  localparam int WD_W  = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(1 << AVG_LOG2);
  localparam logic [3:0]       PH_LAST  = 4'(SAMPLE_DLY - 1);
  localparam logic [WD_W-1:0]  WD_LAST  = WD_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {SYNC, POS_HALF, NEG_HALF, LOST} state_t;

  state_t                  state_q, state_d;
  logic                    sync1_q, sync1_d, sync2_q, sync2_d, prev_q, prev_d;
  logic [3:0]              phase_q, phase_d;
  logic                    taken_q, taken_d;
  logic [2:0]              p_lvl_q, p_lvl_d, n_lvl_q, n_lvl_d;
  logic                    bad_q, bad_d;
  logic signed [ACC_W-1:0] sum_q, sum_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [WD_W-1:0]         wd_q, wd_d;
  logic signed [3:0]       pos_data_q, pos_data_d;
  logic                    pos_valid_q, pos_valid_d;
  logic                    code_err_q, code_err_d;
  logic                    overrun_q, overrun_d;

  logic                    rise, fall, timeout;
  logic                    code_ok;
  logic [2:0]              lvl;
  logic                    in_half, sample_now, half_done, bad_now, new_result;
  logic [2:0]              p_cur, n_cur;
  logic signed [3:0]       diff;
  logic signed [ACC_W-1:0] sum_next;
  logic [CNT_W-1:0]        cnt_next;

  always_comb begin
    lvl     = 3'd0;
    code_ok = 1'b1;
    case (adcbits)
      5'b00001: lvl = 3'd1;
      5'b00011: lvl = 3'd2;
      5'b00111: lvl = 3'd3;
      5'b01111: lvl = 3'd4;
      5'b11111: lvl = 3'd5;
      default:  code_ok = 1'b0;
    endcase
  end

  // NOTE: every signal written here gets a default first, so no path can leave
  // one unassigned and infer a latch.
  always_comb begin
    sync1_d     = inp;
    sync2_d     = sync1_q;
    prev_d      = sync2_q;
    rise        = sync2_q & ~prev_q;
    fall        = ~sync2_q & prev_q;

    state_d     = state_q;
    phase_d     = phase_q;
    taken_d     = taken_q;
    p_lvl_d     = p_lvl_q;
    n_lvl_d     = n_lvl_q;
    bad_d       = bad_q;
    sum_d       = sum_q;
    cnt_d       = cnt_q;
    wd_d        = wd_q;
    pos_data_d  = pos_data_q;
    pos_valid_d = pos_valid_q;
    overrun_d   = overrun_q;
    code_err_d  = 1'b0;
    new_result  = 1'b0;
    timeout     = 1'b0;

    // A sample landing on the same clock as the closing strobe still counts.
    in_half    = (state_q == POS_HALF) || (state_q == NEG_HALF);
    sample_now = in_half && !taken_q && (phase_q == PH_LAST);
    half_done  = taken_q | sample_now;
    bad_now    = bad_q | (sample_now & ~code_ok);
    p_cur      = (sample_now && state_q == POS_HALF) ? lvl : p_lvl_q;
    n_cur      = (sample_now && state_q == NEG_HALF) ? lvl : n_lvl_q;
    diff       = $signed({1'b0, p_cur}) - $signed({1'b0, n_cur});
    sum_next   = sum_q + {{(ACC_W-4){diff[3]}}, diff};
    cnt_next   = cnt_q + CNT_W'(1);

    if (in_half && !taken_q) phase_d = phase_q + 4'd1;
    if (sample_now) begin
      taken_d    = 1'b1;
      code_err_d = ~code_ok;
      bad_d      = bad_now;
      if (state_q == POS_HALF) p_lvl_d = lvl;
      else                     n_lvl_d = lvl;
    end

    if (rise || fall)         wd_d = '0;
    else if (wd_q == WD_LAST) timeout = 1'b1;
    else                      wd_d = wd_q + WD_W'(1);

    case (state_q)
      SYNC, LOST: begin
        if (rise) begin
          state_d = POS_HALF;
          phase_d = '0;
          taken_d = 1'b0;
          bad_d   = 1'b0;
        end
      end
      POS_HALF: begin
        if (fall) begin
          state_d = NEG_HALF;
          phase_d = '0;
          taken_d = 1'b0;
          if (!half_done) bad_d = 1'b1;
        end
      end
      NEG_HALF: begin
        if (rise) begin
          if (!bad_now && half_done) begin
            if (cnt_next == CNT_FULL) begin
              new_result = 1'b1;
              sum_d      = '0;
              cnt_d      = '0;
            end else begin
              sum_d = sum_next;
              cnt_d = cnt_next;
            end
          end
          state_d = POS_HALF;
          phase_d = '0;
          taken_d = 1'b0;
          bad_d   = 1'b0;
        end
      end
      default: state_d = SYNC;
    endcase

    if (timeout) begin
      state_d = LOST;
      sum_d   = '0;
      cnt_d   = '0;
      bad_d   = 1'b0;
    end

    if (new_result) begin
      pos_data_d  = 4'(sum_next >>> AVG_LOG2);
      pos_valid_d = 1'b1;
      if (pos_valid_q && !pos_ready) overrun_d = 1'b1;
    end else if (pos_valid_q && pos_ready) begin
      pos_valid_d = 1'b0;
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the values from before this edge, independent of statement order.
  always_ff @(posedge mclk) begin
    if (!mrst) begin
      state_q     <= SYNC;
      sync1_q     <= 1'b0;
      sync2_q     <= 1'b0;
      prev_q      <= 1'b0;
      phase_q     <= '0;
      taken_q     <= 1'b0;
      p_lvl_q     <= '0;
      n_lvl_q     <= '0;
      bad_q       <= 1'b0;
      sum_q       <= '0;
      cnt_q       <= '0;
      wd_q        <= '0;
      pos_data_q  <= '0;
      pos_valid_q <= 1'b0;
      code_err_q  <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      sync1_q     <= sync1_d;
      sync2_q     <= sync2_d;
      prev_q      <= prev_d;
      phase_q     <= phase_d;
      taken_q     <= taken_d;
      p_lvl_q     <= p_lvl_d;
      n_lvl_q     <= n_lvl_d;
      bad_q       <= bad_d;
      sum_q       <= sum_d;
      cnt_q       <= cnt_d;
      wd_q        <= wd_d;
      pos_data_q  <= pos_data_d;
      pos_valid_q <= pos_valid_d;
      code_err_q  <= code_err_d;
      overrun_q   <= overrun_d;
    end
  end

  assign pos_data  = pos_data_q;
  assign pos_valid = pos_valid_q;
  assign code_err  = code_err_q;
  assign overrun   = overrun_q;
  assign exc_lost  = (state_q == LOST);

endmodule

// File: tb/tb_lvdt_demod_avg.sv
// Bench for lvdt_demod_avg: excitation periods are driven as 14-clock halves and the
// results are predicted by a period-level arithmetic model (sum of P-N, floor average).
module tb_lvdt_demod_avg;
  localparam int SAMPLE_DLY = 10;
  localparam int AVG_LOG2   = 3;
  localparam int TIMEOUT    = 64;
  localparam int NPER       = 1 << AVG_LOG2;
  localparam int HALF       = 14;

  logic              mclk = 1'b0;
  logic              mrst = 1'b0;
  logic              inp = 1'b0;
  logic              pos_ready = 1'b1;
  logic [4:0]        adcbits = 5'b00001;
  logic signed [3:0] pos_data;
  logic              pos_valid, code_err, overrun, exc_lost;

  int n_tests = 0;
  int n_fail  = 0;

  lvdt_demod_avg #(
    .SAMPLE_DLY(SAMPLE_DLY),
    .AVG_LOG2  (AVG_LOG2),
    .TIMEOUT   (TIMEOUT)
  ) dut (
    .mclk     (mclk),
    .mrst     (mrst),
    .inp      (inp),
    .adcbits  (adcbits),
    .pos_data (pos_data),
    .pos_valid(pos_valid),
    .pos_ready(pos_ready),
    .code_err (code_err),
    .overrun  (overrun),
    .exc_lost (exc_lost)
  );

  always #5 mclk = ~mclk;

  // Period-level reference model state.
  int         m_sum = 0;
  int         m_cnt = 0;
  bit         m_open = 0;
  bit         m_valid = 0;
  bit         m_ovr = 0;
  logic [4:0] cur_p = '0;
  logic [4:0] cur_n = '0;
  bit         cur_p_taken = 0;
  bit         cur_n_taken = 0;
  int         obs_q[$];

  typedef struct {
    logic [4:0] pa, na, pb, nb;
    logic [7:0] mask;
    int         exp;
  } vec_t;

  vec_t       vecs[6];
  logic [4:0] valid_codes[5];

  task automatic check(input string name, input logic signed [31:0] act,
                       input logic signed [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int lv(input logic [4:0] code);
    case (code)
      5'b00001: return 1;
      5'b00011: return 2;
      5'b00111: return 3;
      5'b01111: return 4;
      5'b11111: return 5;
      default:  return 0;
    endcase
  endfunction

  function automatic int floor_div(input int a, input int b);
    int q;
    q = a / b;
    if ((a % b != 0) && (a < 0)) q = q - 1;
    return q;
  endfunction

  task automatic model_reset();
    m_sum = 0; m_cnt = 0; m_open = 0; m_valid = 0; m_ovr = 0;
  endtask

  // One excitation half of len clocks; a high half completes the previous period.
  task automatic drive_half(input logic lvl, input logic [4:0] code, input int len,
                            input bit chk_lost);
    bit due;
    int exp_d;
    bit taken;
    due   = 0;
    exp_d = 0;
    taken = (len >= HALF);
    @(negedge mclk);
    inp     = lvl;
    adcbits = code;
    if (lvl) begin
      if (m_open && cur_p_taken && cur_n_taken && lv(cur_p) != 0 && lv(cur_n) != 0) begin
        m_sum += lv(cur_p) - lv(cur_n);
        m_cnt++;
        if (m_cnt == NPER) begin
          due   = 1;
          exp_d = floor_div(m_sum, NPER);
          m_sum = 0;
          m_cnt = 0;
        end
      end
      m_open      = 1;
      cur_p       = code;
      cur_p_taken = taken;
    end else begin
      cur_n       = code;
      cur_n_taken = taken;
    end
    for (int i = 1; i <= len; i++) begin
      @(posedge mclk); #1;
      if (chk_lost && i == 2) check("exc_lost_held", exc_lost, 1);
      if (chk_lost && i == 3) check("exc_lost_clear", exc_lost, 0);
      if (i == 3) begin
        if (due) begin
          if (m_valid && !pos_ready) m_ovr = 1;
          m_valid = 1;
          check("result_valid", pos_valid, 1);
          check("result_data", pos_data, exp_d);
          obs_q.push_back(int'(pos_data));
        end else begin
          check("no_new_result", pos_valid, m_valid);
        end
        check("overrun", overrun, m_ovr);
      end
      if (i == 4 && m_valid && pos_ready) begin
        check("valid_pulse_end", pos_valid, 0);
        m_valid = 0;
      end
      if (i == 13 && taken) check("code_err_pulse", code_err, (lv(code) == 0));
      if (i == 14 && taken) check("code_err_clear", code_err, 0);
    end
  endtask

  task automatic period(input logic [4:0] p, input logic [4:0] n);
    drive_half(1'b1, p, HALF, 1'b0);
    drive_half(1'b0, n, HALF, 1'b0);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_pos_data"}, pos_data, 0);
    check({tag, "_pos_valid"}, pos_valid, 0);
    check({tag, "_code_err"}, code_err, 0);
    check({tag, "_overrun"}, overrun, 0);
    check({tag, "_exc_lost"}, exc_lost, 0);
  endtask

  initial begin
    logic [4:0] rp, rn;
    valid_codes = '{5'b00001, 5'b00011, 5'b00111, 5'b01111, 5'b11111};
    vecs[0] = '{pa: 5'b11111, na: 5'b00001, pb: 5'b11111, nb: 5'b00001, mask: 8'h00, exp:  4};
    vecs[1] = '{pa: 5'b00001, na: 5'b11111, pb: 5'b00001, nb: 5'b11111, mask: 8'h00, exp: -4};
    vecs[2] = '{pa: 5'b00111, na: 5'b00111, pb: 5'b00111, nb: 5'b00111, mask: 8'h00, exp:  0};
    vecs[3] = '{pa: 5'b00011, na: 5'b00001, pb: 5'b00111, nb: 5'b00111, mask: 8'hAA, exp:  0};
    vecs[4] = '{pa: 5'b00011, na: 5'b00001, pb: 5'b00111, nb: 5'b00001, mask: 8'h80, exp:  1};
    vecs[5] = '{pa: 5'b00001, na: 5'b00011, pb: 5'b00111, nb: 5'b00111, mask: 8'hAA, exp: -1};

    repeat (3) @(posedge mclk);
    #1;
    check_all_zero("reset");
    @(negedge mclk);
    mrst = 1'b1;

    // Directed averages, one result per vector.
    for (int v = 0; v < 6; v++)
      for (int p = 0; p < NPER; p++)
        period(vecs[v].mask[p] ? vecs[v].pb : vecs[v].pa,
               vecs[v].mask[p] ? vecs[v].nb : vecs[v].na);
    period(5'b11111, 5'b00001);
    check("vec_result_count", obs_q.size(), 6);
    for (int v = 0; v < 6; v++)
      if (v < obs_q.size()) check($sformatf("vec%0d_data", v), obs_q[v], vecs[v].exp);

    // Invalid code in one period: it is dropped and the result needs a 9th period.
    for (int j = 0; j < NPER; j++) period((j == 2) ? 5'b10101 : 5'b11111, 5'b00001);

    // Randomized periods checked against the model.
    for (int j = 0; j < 20; j++) begin
      rp = ($urandom_range(0, 7) == 0) ? 5'($urandom_range(0, 31)) : valid_codes[$urandom_range(0, 4)];
      rn = ($urandom_range(0, 7) == 0) ? 5'($urandom_range(0, 31)) : valid_codes[$urandom_range(0, 4)];
      period(rp, rn);
    end

    // Excitation stops after the last fall strobe (posedge 3 of that half).
    repeat (51) @(posedge mclk);
    @(posedge mclk); #1;
    check("exc_lost_before_timeout", exc_lost, 0);
    @(posedge mclk); #1;
    check("exc_lost_at_timeout", exc_lost, 1);
    m_sum = 0; m_cnt = 0; m_open = 0;

    // Restart with pos_ready low across two results.
    pos_ready = 1'b0;
    drive_half(1'b1, 5'b11111, HALF, 1'b1);
    drive_half(1'b0, 5'b00001, HALF, 1'b0);
    for (int j = 1; j < NPER; j++) period(5'b11111, 5'b00001);
    for (int j = 0; j < NPER; j++) period(5'b00001, 5'b11111);
    drive_half(1'b1, 5'b00111, HALF, 1'b0);
    check("ovr_flag", overrun, 1);
    check("ovr_data_second", pos_data, -4);
    check("ovr_valid_held", pos_valid, 1);
    @(negedge mclk);
    pos_ready = 1'b1;
    @(posedge mclk); #1;
    check("accept_clears_valid", pos_valid, 0);
    check("overrun_sticky", overrun, 1);
    m_valid = 0;

    // Reset in the middle of a negative half.
    drive_half(1'b0, 5'b00001, 5, 1'b0);
    @(negedge mclk);
    mrst = 1'b0;
    @(posedge mclk); #1;
    check_all_zero("mid_reset");
    @(negedge mclk);
    mrst = 1'b1;
    model_reset();

    // First result after reset needs a full set of good periods.
    obs_q.delete();
    for (int j = 0; j < NPER; j++) period(5'b01111, 5'b00011);
    drive_half(1'b1, 5'b11111, HALF, 1'b0);
    check("post_reset_result_count", obs_q.size(), 1);
    if (obs_q.size() > 0) check("post_reset_data", obs_q[0], 2);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/lvdt_demod_avg.md
LVDT_DEMOD_AVG -- requirements
Module: lvdt_demod_avg

Interface
REQ-001 Parameter SAMPLE_DLY, default 10: clocks after a detected excitation edge at which the ADC code is sampled (1..15).
REQ-002 Parameter AVG_LOG2, default 3: log2 of the number of excitation periods averaged per result.
REQ-003 Parameter TIMEOUT, default 64: clocks without any excitation edge before loss is declared.
REQ-004 mclk  input  1  sole clock, 200 kHz nominal; all logic on the rising edge.
REQ-005 mrst  input  1  reset, synchronous, active-low.
REQ-006 inp  input  1  excitation square wave, 10 kHz, asynchronous to mclk.
REQ-007 adcbits  input  5  ADC thermometer code; valid codes are 00001, 00011, 00111, 01111 and 11111.
REQ-008 pos_data  output  4+AVG_LOG2 is not used; width 4, signed two's-complement averaged position.
REQ-009 pos_valid  output  1  pos_data holds an unconsumed result.
REQ-010 pos_ready  input  1  downstream accepts pos_data when pos_valid and pos_ready are both high.
REQ-011 code_err  output  1  one-clock pulse on an invalid sampled code.
REQ-012 overrun  output  1  sticky flag: a result was overwritten before it was accepted.
REQ-013 exc_lost  output  1  level, high while excitation is absent.

Function
REQ-014 inp shall pass through a 2-flop synchronizer and an edge register; rise/fall strobes occur 3 clocks after the pin edge.
REQ-015 Code-to-level map: 00001->1, 00011->2, 00111->3, 01111->4, 11111->5; any other code sets code_err for 1 clock and marks the current period bad.
REQ-016 FSM states: SYNC, POS_HALF, NEG_HALF, LOST; reset state SYNC.
REQ-017 SYNC->POS_HALF on rise strobe; POS_HALF->NEG_HALF on fall strobe; NEG_HALF->POS_HALF on rise strobe, which completes one period.
REQ-018 On entry to POS_HALF or NEG_HALF, a phase counter is cleared; when it equals SAMPLE_DLY-1, adcbits is sampled as P (positive half) or N (negative half).
REQ-019 If a half ends before its sample is taken, the period shall be marked bad.
REQ-020 On period completion, if the period is good, d = P - N (signed, -4..+4) is added to a signed accumulator of width 4+AVG_LOG2 and the period count increments; bad periods are discarded and leave count and sum unchanged.
REQ-021 When the count reaches 2^AVG_LOG2, pos_data = sum arithmetically shifted right by AVG_LOG2 (floor), registered one clock after the completing rise strobe; pos_valid rises on the same clock; sum and count clear.
REQ-022 pos_valid shall stay high, with pos_data stable, until it is accepted; it clears on the clock after acceptance.
REQ-023 If a new result arrives while pos_valid is high and not accepted on that clock, pos_data is overwritten, pos_valid stays high and overrun sets; if acceptance and a new result occur on the same clock, the new result loads with no overrun.
REQ-024 A watchdog counter clears on any rise or fall strobe; on reaching TIMEOUT from any state it forces LOST, asserts exc_lost and clears sum, count and the bad flag.
REQ-025 LOST->POS_HALF on a rise strobe, which deasserts exc_lost; a fall strobe in LOST or SYNC is ignored.
REQ-026 overrun clears only on reset.

Reset
REQ-027 With mrst low at a mclk rising edge, the following shall be cleared on that edge, overriding all other activity including a mid-period state: state=SYNC, pos_data=0, pos_valid=0, code_err=0, overrun=0, exc_lost=0, and the synchronizer, counters and accumulator all 0.
REQ-028 The first result after reset requires 2^AVG_LOG2 complete good periods, counted from the first rise strobe.

Verification
REQ-029 Defaults, adcbits=11111 in high halves and 00001 in low halves for 8 periods, pos_ready=1 -> pos_data=+4 with a 1-clock pos_valid pulse, 1 clock after the 8th completing rise strobe.
REQ-030 Reversed codes (00001 high, 11111 low) -> pos_data=-4 (1100); constant 00111 in both halves -> pos_data=0.
REQ-031 Periods alternating d=+1 and d=0 for 8 periods -> sum=4, pos_data=0 (floor); 7 periods of +1 plus one of +2 -> pos_data=+1.
REQ-032 adcbits=10101 at one sample point -> code_err pulse, that period discarded, result appears after the 9th period.
REQ-033 pos_ready=0 across two results -> overrun=1, pos_data equals the second result, pos_valid held; raising pos_ready -> pos_valid clears the next clock.
REQ-034 inp held constant -> exc_lost=1 exactly TIMEOUT clocks after the last strobe; inp restarted -> exc_lost=0 at the first rise strobe; mrst pulsed low mid-NEG_HALF -> all outputs 0 on the next edge.
